// File: rtl/iq_issue_sel_pkg.sv
// Shared types for the issue stage: decoded-op layout, functional-unit class
// and register-field accessors that hide the "used" flags from callers.
package iq_issue_sel_pkg;

  localparam int REG_W = 5;
  localparam int TAG_W = 8;

  typedef logic [REG_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_LSU = 2'd2
  } fu_class_t;

  typedef struct packed {
    fu_class_t fu_class;
    logic      dst_used;
    reg_idx_t  dst;
    logic      src_a_used;
    reg_idx_t  src_a;
    logic      src_b_used;
    reg_idx_t  src_b;
  } dec_inst_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    dec_inst_t        dec_inst;
  } iq_entry_t;

  function automatic fu_class_t fu_class_of(input iq_entry_t e);
    return e.dec_inst.fu_class;
  endfunction

  // An unused register field reads as r0, which never creates a hazard.
  function automatic reg_idx_t dst_of(input iq_entry_t e);
    return e.dec_inst.dst_used ? e.dec_inst.dst : '0;
  endfunction

  function automatic reg_idx_t src_a_of(input iq_entry_t e);
    return e.dec_inst.src_a_used ? e.dec_inst.src_a : '0;
  endfunction

  function automatic reg_idx_t src_b_of(input iq_entry_t e);
    return e.dec_inst.src_b_used ? e.dec_inst.src_b : '0;
  endfunction

endpackage

// File: rtl/iss_hazard_chk.sv
// Pairwise RAW/WAW check across the visible head slots; hz[k] is set when
// slot k depends on, or overwrites the destination of, any older slot.
module iss_hazard_chk
  import iq_issue_sel_pkg::*;
#(
  parameter int EXT_COUNT = 4
) (
  input  reg_idx_t [EXT_COUNT-1:0] dst,
  input  reg_idx_t [EXT_COUNT-1:0] src_a,
  input  reg_idx_t [EXT_COUNT-1:0] src_b,
  output logic     [EXT_COUNT-1:0] hz
);

  // The oldest slot has nothing older to conflict with, so its sources are idle.
  logic unused_src0;
  assign unused_src0 = ^{src_a[0], src_b[0]};

  always_comb begin
    hz = '0;
    for (int k = 1; k < EXT_COUNT; k++) begin
      for (int j = 0; j < k; j++) begin
        if ((dst[j] != '0) &&
            ((dst[j] == src_a[k]) || (dst[j] == src_b[k]) || (dst[j] == dst[k]))) begin
          hz[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/iq_issue_sel.sv
// In-order issue select: takes the longest issuable prefix of the queue head,
// drives the queue extract handshake and registers ops onto ALU/MUL/LSU ports.
module iq_issue_sel
  import iq_issue_sel_pkg::*;
#(
  parameter int EXT_COUNT    = 4,
  parameter int ALU_COUNT    = 2,
  parameter int MUL_LAT      = 3,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT),
  parameter int MULCNTW      = $clog2(MUL_LAT + 1)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               flush,
  input  logic      [EXT_COUNT-1:0]          head_valid,
  input  iq_entry_t [EXT_COUNT-1:0]          head_elements,
  input  logic      [EXT_COUNT-1:0]          ops_ready,
  input  logic                               lsu_ready,
  output logic                               ext_enable,
  output logic      [EXTCOUNTLOG2-1:0]       ext_consumed,
  output logic      [ALU_COUNT-1:0]          alu_valid,
  output iq_entry_t [ALU_COUNT-1:0]          alu_op,
  output logic                               mul_valid,
  output iq_entry_t                          mul_op,
  output logic                               lsu_valid,
  output iq_entry_t                          lsu_op,
  output logic                               mul_busy
);

  reg_idx_t [EXT_COUNT-1:0] slot_dst;
  reg_idx_t [EXT_COUNT-1:0] slot_src_a;
  reg_idx_t [EXT_COUNT-1:0] slot_src_b;
  logic     [EXT_COUNT-1:0] hz;

  logic [MULCNTW-1:0] mul_cnt;

  int        n_sel;
  int        alu_used;
  logic      scan_on;
  logic      res_ok;
  logic      slot_ok;
  logic      mul_taken;
  logic      lsu_taken;

  logic      [ALU_COUNT-1:0] alu_v_nxt;
  iq_entry_t [ALU_COUNT-1:0] alu_op_nxt;
  iq_entry_t                 mul_op_nxt;
  iq_entry_t                 lsu_op_nxt;

  always_comb begin
    for (int k = 0; k < EXT_COUNT; k++) begin
      slot_dst[k]   = dst_of(head_elements[k]);
      slot_src_a[k] = src_a_of(head_elements[k]);
      slot_src_b[k] = src_b_of(head_elements[k]);
    end
  end

  iss_hazard_chk #(
    .EXT_COUNT (EXT_COUNT)
  ) u_hazard (
    .dst   (slot_dst),
    .src_a (slot_src_a),
    .src_b (slot_src_b),
    .hz    (hz)
  );

  assign mul_busy = (mul_cnt != '0);

  // Prefix scan: the first slot that fails any check ends selection.
  always_comb begin
    n_sel      = 0;
    alu_used   = 0;
    scan_on    = 1'b1;
    res_ok     = 1'b0;
    slot_ok    = 1'b0;
    mul_taken  = 1'b0;
    lsu_taken  = 1'b0;
    alu_v_nxt  = '0;
    alu_op_nxt = alu_op;
    mul_op_nxt = mul_op;
    lsu_op_nxt = lsu_op;

    for (int k = 0; k < EXT_COUNT; k++) begin
      case (fu_class_of(head_elements[k]))
        FU_ALU:  res_ok = (alu_used < ALU_COUNT);
        FU_MUL:  res_ok = !mul_busy && !mul_taken;
        FU_LSU:  res_ok = lsu_ready && !lsu_taken;
        default: res_ok = 1'b0;
      endcase

      slot_ok = scan_on && head_valid[k] && ops_ready[k] && !hz[k] && res_ok;

      if (!slot_ok) begin
        scan_on = 1'b0;
      end else begin
        n_sel = n_sel + 1;
        case (fu_class_of(head_elements[k]))
          FU_ALU: begin
            for (int p = 0; p < ALU_COUNT; p++) begin
              if (p == alu_used) begin
                alu_v_nxt[p]  = 1'b1;
                alu_op_nxt[p] = head_elements[k];
              end
            end
            alu_used = alu_used + 1;
          end
          FU_MUL: begin
            mul_taken  = 1'b1;
            mul_op_nxt = head_elements[k];
          end
          FU_LSU: begin
            lsu_taken  = 1'b1;
            lsu_op_nxt = head_elements[k];
          end
          default: ;
        endcase
      end
    end
  end

  assign ext_enable   = reset_n && !flush && (n_sel != 0);
  assign ext_consumed = (n_sel == 0) ? '0 : EXTCOUNTLOG2'(n_sel - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_valid <= '0;
      mul_valid <= 1'b0;
      lsu_valid <= 1'b0;
      mul_cnt   <= '0;
    end else if (flush) begin
      // A flushed MUL is dropped, so the unit is free immediately.
      alu_valid <= '0;
      mul_valid <= 1'b0;
      lsu_valid <= 1'b0;
      mul_cnt   <= '0;
    end else begin
      alu_valid <= ext_enable ? alu_v_nxt : '0;
      mul_valid <= ext_enable && mul_taken;
      lsu_valid <= ext_enable && lsu_taken;
      if (ext_enable && mul_taken) begin
        mul_cnt <= MULCNTW'(MUL_LAT - 1);
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - MULCNTW'(1);
      end
    end
  end

  // Op payloads carry no reset; ports that do not issue keep their last op.
  always_ff @(posedge clock) begin
    if (ext_enable) begin
      alu_op <= alu_op_nxt;
      mul_op <= mul_op_nxt;
      lsu_op <= lsu_op_nxt;
    end
  end

endmodule

// File: doc/iq_issue_sel.md
Name: iq_issue_sel

Overview:
In-order issue stage on the extract side of the issue-queue circular buffer. It inspects up to EXT_COUNT head entries each cycle and picks the longest issuable in-order prefix. It drives the queue's ext_enable/ext_consumed handshake and registers the selected ops onto ALU, MUL and LSU issue ports. A MUL busy counter and an LSU ready handshake give it real resource state.

Parameters:
EXT_COUNT, 4, head entries visible from the queue (matches the queue's EXT_COUNT)
ALU_COUNT, 2, number of ALU issue ports
MUL_LAT, 3, cycles the non-pipelined MUL stays occupied per op (>=1)
EXTCOUNTLOG2, $clog2(EXT_COUNT), width of ext_consumed
MULCNTW, $clog2(MUL_LAT+1), width of the MUL busy counter

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous, active-low reset
flush  in  1  pipeline flush (same signal the queue receives)
head_valid  in  [EXT_COUNT]  queue ext_valid, slot 0 = oldest
head_elements  in  iq_entry_t[EXT_COUNT]  queue out_elements
ops_ready  in  [EXT_COUNT]  scoreboard: all sources of slot k available this cycle
lsu_ready  in  1  LSU can accept an op this cycle
ext_enable  out  1  consume from queue (combinational)
ext_consumed  out  EXTCOUNTLOG2  number consumed minus 1 (combinational)
alu_valid  out  [ALU_COUNT]  registered ALU issue valid
alu_op  out  iq_entry_t[ALU_COUNT]  registered ALU op
mul_valid  out  1  registered MUL issue valid
mul_op  out  iq_entry_t  registered MUL op
lsu_valid  out  1  registered LSU issue valid
lsu_op  out  iq_entry_t  registered LSU op
mul_busy  out  1  MUL busy counter nonzero

Behaviour:
- Scan slots k=0..EXT_COUNT-1 in order. Slot k is selected only if all of the following hold:
  - slots 0..k-1 are selected;
  - head_valid[k] and ops_ready[k] are set;
  - no RAW or WAW hazard exists against any selected earlier slot. The test uses dst_of/src_a_of/src_b_of; register 0 never counts as a hazard;
  - a resource is free for its class:
    - FU_ALU: ALUs already used < ALU_COUNT;
    - FU_MUL: ~mul_busy and no MUL already selected;
    - FU_LSU: lsu_ready and no LSU already selected.
- The scan stops at the first unselected slot. No skipping, so issue is strictly in order.
- n = number selected. ext_enable = (n>0) & ~flush; ext_consumed = n-1 (truncated to EXTCOUNTLOG2); ext_consumed = 0 when n=0.
- Port assignment: the i-th selected ALU op goes to alu port i. Unused ports have valid=0 and op held.
- Latency: selection is combinational. Issue outputs are registered, so valid appears the cycle after the queue consumes the entry.
- MUL counter:
  - on MUL issue, load MUL_LAT-1;
  - else decrement if nonzero;
  - mul_busy = (cnt!=0);
  - MUL_LAT=1 means back-to-back MULs are allowed.
- flush:
  - ext_enable=0 that cycle;
  - all *_valid <= 0 next edge;
  - MUL counter <= 0 (in-flight MUL is killed).
  - flush has priority over selection.
- Empty queue (all head_valid=0): n=0, ext_enable=0, all valids 0 next cycle.
- A partial head (e.g. only slots 0..1 valid): selection is bounded by head_valid. The queue also clamps ext_consumed to used_count-1, but this block never relies on that clamp.
- Reset (async):
  - all *_valid=0, MUL counter=0, mul_busy=0;
  - ext_enable is forced 0 while reset_n is low;
  - *_op values are don't-care.
- Reset or flush mid-MUL: the counter clears immediately on reset and on the next edge on flush.

Decomposition:
- pipTypes additions:
  - fu_class_t enum {FU_ALU, FU_MUL, FU_LSU};
  - iq_entry_t.dec_inst.fu_class field;
  - functions fu_class_of, dst_of, src_a_of, src_b_of (return 0 when the register is unused).
- One sub-module, iss_hazard_chk: combinational pairwise RAW/WAW matrix over EXT_COUNT slots, output hz[k] = slot k conflicts with some earlier slot. Selection, port mapping and counters stay in iq_issue_sel.

Test Plan:
- 4 valid independent ALU ops, all ready, ALU_COUNT=2 -> ext_enable=1, ext_consumed=1; next cycle alu_valid={1,1} with slot0/slot1 ops, mul_valid=lsu_valid=0.
- Slots ALU(r3<-..), ALU(..<-r3), ALU, ALU all ready -> n=1, ext_consumed=0, only alu_valid[0] next cycle.
- MUL at slot 0 in cycle 0, MUL at slot 0 in cycles 1..3, MUL_LAT=3:
  - cycle 0 issues, mul_busy=1 for cycles 1-2;
  - second MUL consumed in cycle 3, mul_valid=1 at cycle 4.
- Slots LSU, ALU with lsu_ready=0 -> ext_enable=0, no valids. With lsu_ready=1 -> n=2, lsu_valid=1 and alu_valid[0]=1 next cycle.
- flush asserted while MUL counter=2 and 3 slots issuable -> ext_enable=0 that cycle; next cycle all valids 0 and mul_busy=0.
- reset_n pulsed low mid-stream -> valids and mul_busy go 0 asynchronously; after release, head_valid all 0 gives ext_enable=0.
